// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 ALU op encoding and M-extension unit types
package rv32_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHU  = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17,
    ALU_LUI    = 5'd18
  } aluop_e;

  localparam logic [4:0] MUL_OPS_LO = 5'd10;
  localparam logic [4:0] MUL_OPS_HI = 5'd13;
  localparam logic [4:0] DIV_OPS_LO = 5'd14;
  localparam logic [4:0] DIV_OPS_HI = 5'd17;

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    DIV_RUN
  } muldiv_state_e;

  function automatic logic is_mul_op(input logic [4:0] op);
    return (op >= MUL_OPS_LO) && (op <= MUL_OPS_HI);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op >= DIV_OPS_LO) && (op <= DIV_OPS_HI);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// rtl/muldiv_div_step.sv - combinational N-bit restoring division step
// Dividend bits are consumed MSB-first from quot_in; quotient bits shift in at the LSB.
module muldiv_div_step #(
  parameter int N  = 4,
  parameter int QW = 40
) (
  input  logic [31:0]   rem_in,
  input  logic [QW-1:0] quot_in,
  input  logic [31:0]   divisor,
  output logic [31:0]   rem_out,
  output logic [QW-1:0] quot_out
);

  logic [32:0]   r;
  logic [QW-1:0] q;

  always_comb begin
    r = {1'b0, rem_in};
    q = quot_in;
    for (int i = 0; i < N; i++) begin
      r = {r[31:0], q[QW-1]};
      q = {q[QW-2:0], 1'b0};
      if (r >= {1'b0, divisor}) begin
        r    = r - {1'b0, divisor};
        q[0] = 1'b1;
      end
    end
    rem_out  = r[31:0];
    quot_out = q;
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle RV32M multiply/divide execute unit
// MULDIV_SVA_EN compiles in embedded protocol and latency assertions.
module muldiv_unit
  import rv32_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  aluop,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  // Cycle 0 of a divide prepares magnitudes; the remaining DIV_LAT-1 cycles each retire DIV_N bits.
  localparam int DIV_STEPS = DIV_LAT - 1;
  localparam int DIV_N     = (32 + DIV_STEPS - 1) / DIV_STEPS;
  localparam int DIV_QW    = DIV_STEPS * DIV_N;

  localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LAST = 6'(DIV_LAT - 1);

  muldiv_state_e     state;
  logic [5:0]        cnt;
  aluop_e            op_q;
  logic [31:0]       opa_q;
  logic [31:0]       opb_q;
  logic [31:0]       divisor_q;
  logic [31:0]       rem_q;
  logic [DIV_QW-1:0] quot_q;

  logic              accept;
  logic              a_sgn;
  logic              b_sgn;
  logic signed [32:0] a33;
  logic signed [32:0] b33;
  logic [63:0]       prod;
  logic [31:0]       mul_res;

  logic              signed_div;
  logic              sign_a;
  logic              sign_b;
  logic [31:0]       mag_a;
  logic [31:0]       mag_b;
  logic              div_zero;
  logic [31:0]       step_rem;
  logic [DIV_QW-1:0] step_quot;
  logic [31:0]       q_fin;
  logic [31:0]       div_res;

  assign accept = start & ~busy & (is_mul_op(aluop) | is_div_op(aluop)) & ~flush;

  assign a_sgn   = (op_q == ALU_MULH) || (op_q == ALU_MULHSU);
  assign b_sgn   = (op_q == ALU_MULH);
  assign a33     = {a_sgn & opa_q[31], opa_q};
  assign b33     = {b_sgn & opb_q[31], opb_q};
  assign prod    = 64'(a33 * b33);
  assign mul_res = (op_q == ALU_MUL) ? prod[31:0] : prod[63:32];

  assign signed_div = (op_q == ALU_DIV) || (op_q == ALU_REM);
  assign sign_a     = signed_div & opa_q[31];
  assign sign_b     = signed_div & opb_q[31];
  assign mag_a      = sign_a ? -opa_q : opa_q;
  assign mag_b      = sign_b ? -opb_q : opb_q;
  assign div_zero   = (opb_q == 32'd0);

  muldiv_div_step #(
    .N  (DIV_N),
    .QW (DIV_QW)
  ) u_div_step (
    .rem_in   (rem_q),
    .quot_in  (quot_q),
    .divisor  (divisor_q),
    .rem_out  (step_rem),
    .quot_out (step_quot)
  );

  assign q_fin = step_quot[31:0];

  // Sign fix-up on the last step's output; overflow falls out of the magnitude path naturally.
  always_comb begin
    div_res = 32'd0;
    case (op_q)
      ALU_DIV:  div_res = div_zero ? 32'hFFFF_FFFF : ((sign_a ^ sign_b) ? -q_fin : q_fin);
      ALU_DIVU: div_res = div_zero ? 32'hFFFF_FFFF : q_fin;
      ALU_REM:  div_res = div_zero ? opa_q : (sign_a ? -step_rem : step_rem);
      ALU_REMU: div_res = div_zero ? opa_q : step_rem;
      default:  div_res = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 6'd0;
      op_q      <= ALU_ADD;
      opa_q     <= 32'd0;
      opb_q     <= 32'd0;
      divisor_q <= 32'd0;
      rem_q     <= 32'd0;
      quot_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= aluop_e'(aluop);
            opa_q <= opA;
            opb_q <= opB;
            cnt   <= 6'd0;
            busy  <= 1'b1;
            state <= is_mul_op(aluop) ? MUL_RUN : DIV_RUN;
          end
        end
        MUL_RUN: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == MUL_LAST) begin
            result <= mul_res;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        DIV_RUN: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == 6'd0) begin
            divisor_q <= mag_b;
            quot_q    <= DIV_QW'(mag_a);
            rem_q     <= 32'd0;
            cnt       <= 6'd1;
          end else begin
            rem_q  <= step_rem;
            quot_q <= step_quot;
            if (cnt == DIV_LAST) begin
              result <= div_res;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= IDLE;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MULDIV_SVA_EN
  if (MUL_LAT < 1 || MUL_LAT > 8) begin : g_mul_lat_chk
    $error("muldiv_unit: MUL_LAT out of range 1..8");
  end
  if (DIV_LAT < 3 || DIV_LAT > 33) begin : g_div_lat_chk
    $error("muldiv_unit: DIV_LAT out of range 3..33");
  end

  a_no_start_busy: assert property (@(posedge clk) disable iff (reset) !(start && busy))
    else $error("muldiv_unit: start asserted while busy");

  a_done_pulse: assert property (@(posedge clk) disable iff (reset) done |=> !done)
    else $error("muldiv_unit: done held longer than one cycle");

  a_mul_busy: assert property (@(posedge clk) disable iff (reset || flush)
    (accept && is_mul_op(aluop)) |=> busy [*MUL_LAT] ##1 !busy)
    else $error("muldiv_unit: multiply busy length wrong");

  a_div_busy: assert property (@(posedge clk) disable iff (reset || flush)
    (accept && is_div_op(aluop)) |=> busy [*DIV_LAT] ##1 !busy)
    else $error("muldiv_unit: divide busy length wrong");
`else
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit
module tb_muldiv_unit;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 11;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  aluop;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  muldiv_unit #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .aluop  (aluop),
    .opA    (opA),
    .opB    (opB),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Reference: plain 64-bit arithmetic on the RV32M definitions.
  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          p;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned up;
    int              ia;
    int              ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (op)
      5'd10: begin p = sa * sb; return p[31:0]; end
      5'd11: begin p = sa * sb; return p[63:32]; end
      5'd12: begin up = ua * ub; return up[63:32]; end
      5'd13: begin p = sa * $signed(ub); return p[63:32]; end
      5'd14: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      5'd15: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      5'd16: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      5'd17: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] op);
    return (op <= 5'd13) ? MUL_LAT : DIV_LAT;
  endfunction

  // Launch one op (accepted at the next edge, E0) and observe it up to its done.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int done_at, output int busy_cycles);
    @(posedge clk); #1;
    start = 1'b1; aluop = op; opA = a; opB = b;
    @(posedge clk); #1;
    start = 1'b0; aluop = 5'($urandom); opA = $urandom; opB = $urandom;
    done_at = -1; busy_cycles = 0; res = 32'd0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        done_at = k; res = result;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; flush = 1'b0; aluop = 5'd0; opA = 32'd0; opB = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (result !== 32'd0) begin n_bad++; $display("FAIL reset_result got %h want 0", result); end
  endtask

  task automatic test_mul_directed;
    logic [4:0]  ops [4];
    logic [31:0] as [4];
    logic [31:0] bs [4];
    logic [31:0] ex [4];
    logic [31:0] res;
    int          dat;
    int          bc;
    ops = '{5'd10, 5'd11, 5'd12, 5'd13};
    as  = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    bs  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    ex  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hC000_0000};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], res, dat, bc);
      n_cmp++; if (res !== ex[i]) begin n_bad++; $display("FAIL mul_result op%0d got %h want %h", ops[i], res, ex[i]); end
      n_cmp++; if (dat != MUL_LAT) begin n_bad++; $display("FAIL mul_done_cycle op%0d got %0d want %0d", ops[i], dat, MUL_LAT); end
      n_cmp++; if (bc != MUL_LAT) begin n_bad++; $display("FAIL mul_busy_cycles op%0d got %0d want %0d", ops[i], bc, MUL_LAT); end
    end
  endtask

  task automatic test_div_directed;
    logic [4:0]  ops [8];
    logic [31:0] as [8];
    logic [31:0] bs [8];
    logic [31:0] ex [8];
    logic [31:0] res;
    int          dat;
    int          bc;
    ops = '{5'd14, 5'd16, 5'd15, 5'd17, 5'd14, 5'd17, 5'd14, 5'd16};
    as  = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    bs  = '{32'd3, 32'd3, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    ex  = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], as[i], bs[i], res, dat, bc);
      n_cmp++; if (res !== ex[i]) begin n_bad++; $display("FAIL div_result #%0d got %h want %h", i, res, ex[i]); end
      n_cmp++; if (dat != DIV_LAT) begin n_bad++; $display("FAIL div_done_cycle #%0d got %0d want %0d", i, dat, DIV_LAT); end
      n_cmp++; if (bc != DIV_LAT) begin n_bad++; $display("FAIL div_busy_cycles #%0d got %0d want %0d", i, bc, DIV_LAT); end
    end
  endtask

  task automatic test_random;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] exp_v;
    int          dat;
    int          bc;
    for (int i = 0; i < 60; i++) begin
      op = 5'(10 + $urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 17); end
        3: b = 32'($signed(-$urandom_range(1, 9)));
        default: ;
      endcase
      exp_v = ref_result(op, a, b);
      issue(op, a, b, res, dat, bc);
      n_cmp++; if (res !== exp_v) begin n_bad++; $display("FAIL rand_result op%0d a=%h b=%h got %h want %h", op, a, b, res, exp_v); end
      n_cmp++; if (dat != ref_lat(op)) begin n_bad++; $display("FAIL rand_latency op%0d got %0d want %0d", op, dat, ref_lat(op)); end
      n_cmp++; if (bc != ref_lat(op)) begin n_bad++; $display("FAIL rand_busy op%0d got %0d want %0d", op, bc, ref_lat(op)); end
    end
  endtask

  task automatic test_invalid_op;
    int seen;
    logic [4:0] bad_ops [3];
    bad_ops = '{5'd0, 5'd9, 5'd18};
    for (int i = 0; i < 3; i++) begin
      seen = 0;
      @(posedge clk); #1;
      start = 1'b1; aluop = bad_ops[i]; opA = $urandom; opB = $urandom;
      @(posedge clk); #1 start = 1'b0;
      for (int k = 0; k < 15; k++) begin
        @(negedge clk);
        if (busy || done) seen++;
      end
      n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL invalid_op %0d active cycles got %0d want 0", bad_ops[i], seen); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res;
    int          dat;
    int          bc;
    int          dones;
    @(posedge clk); #1;
    start = 1'b1; aluop = 5'd15; opA = 32'd1000; opB = 32'd9;
    @(posedge clk); #1 start = 1'b0;
    dat = -1; bc = 0; dones = 0; res = 32'd0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        dones++; dat = k; res = result;
        start = 1'b1; aluop = 5'd10; opA = 32'd12; opB = 32'hFFFF_FFFE;
        break;
      end
      if (k == 4) begin start = 1'b1; aluop = 5'd10; opA = 32'd3; opB = 32'd5; end
      if (k == 5) start = 1'b0;
    end
    n_cmp++; if (dat != DIV_LAT) begin n_bad++; $display("FAIL drop_done_cycle got %0d want %0d", dat, DIV_LAT); end
    n_cmp++; if (res !== 32'd111) begin n_bad++; $display("FAIL drop_result got %h want %h", res, 32'd111); end
    n_cmp++; if (bc != DIV_LAT) begin n_bad++; $display("FAIL drop_busy_cycles got %0d want %0d", bc, DIV_LAT); end
    @(posedge clk); #1 start = 1'b0;
    dat = -1; bc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin dat = k; res = result; break; end
    end
    n_cmp++; if (dat != MUL_LAT) begin n_bad++; $display("FAIL b2b_done_cycle got %0d want %0d", dat, MUL_LAT); end
    n_cmp++; if (res !== 32'hFFFF_FFE8) begin n_bad++; $display("FAIL b2b_result got %h want %h", res, 32'hFFFF_FFE8); end
    n_cmp++; if (bc != MUL_LAT) begin n_bad++; $display("FAIL b2b_busy_cycles got %0d want %0d", bc, MUL_LAT); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] res;
    int          dat;
    int          bc;
    int          dones;
    logic        busy_after;
    logic [31:0] res_after;
    issue(5'd10, 32'd6, 32'd7, res, dat, bc);
    @(posedge clk); #1;
    start = 1'b1; aluop = 5'd14; opA = 32'd1234; opB = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    dones = 0; busy_after = 1'bx; res_after = 32'hx;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) dones++;
      if (k == 6) begin busy_after = busy; res_after = result; reset = 1'b0; end
      if (k == 5) reset = 1'b1;
    end
    n_cmp++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy_after); end
    n_cmp++; if (res_after !== 32'd0) begin n_bad++; $display("FAIL rstmid_result got %h want 0", res_after); end
    n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL rstmid_done_count got %0d want 0", dones); end
  endtask

  task automatic test_flush;
    logic [31:0] res;
    int          dat;
    int          bc;
    int          dones;
    logic        busy_after;
    issue(5'd10, 32'd6, 32'd7, res, dat, bc);
    n_cmp++; if (res !== 32'd42) begin n_bad++; $display("FAIL flush_setup got %h want %h", res, 32'd42); end
    @(posedge clk); #1;
    start = 1'b1; aluop = 5'd15; opA = 32'd100; opB = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    dones = 0; busy_after = 1'bx;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) dones++;
      if (k == 11) begin busy_after = busy; flush = 1'b0; end
      if (k == 10) flush = 1'b1;
    end
    n_cmp++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL flush_busy got %b want 0", busy_after); end
    n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL flush_done_count got %0d want 0", dones); end
    n_cmp++; if (result !== 32'd42) begin n_bad++; $display("FAIL flush_result_held got %h want %h", result, 32'd42); end
    issue(5'd15, 32'd100, 32'd7, res, dat, bc);
    n_cmp++; if (res !== 32'd14) begin n_bad++; $display("FAIL post_flush_result got %h want %h", res, 32'd14); end
    n_cmp++; if (dat != DIV_LAT) begin n_bad++; $display("FAIL post_flush_latency got %0d want %0d", dat, DIV_LAT); end
  endtask

  initial begin
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_invalid_op();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
